// File: rtl/addsub_pipe_sat.sv
// Pipelined carry-lookahead adder/subtractor with signed overflow flag.
// Define ADDSUB_SAT_EN to clamp overflowed results; otherwise results wrap.
module addsub_pipe_sat #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             ovfl,
  output logic             zero,
  output logic             neg
);

  localparam int GROUPS = WIDTH / 4;
  localparam int GPS    = GROUPS / STAGES;
  localparam int MSB    = WIDTH - 1;

  // Handshake: a beat moves on a cycle where valid & ready are both high; valid
  // never depends on ready. Any unconsumed output freezes the whole pipe.
  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Register k (k >= 1) holds the state entering stage k; index 0 is unused.
  logic [WIDTH-1:0] a_r [STAGES];
  logic [WIDTH-1:0] b_r [STAGES];
  logic [WIDTH-1:0] s_r [STAGES];
  logic             c_r [STAGES];
  logic             v_r [STAGES];

  logic [WIDTH-1:0] nxt_a [STAGES];
  logic [WIDTH-1:0] nxt_b [STAGES];
  logic [WIDTH-1:0] nxt_s [STAGES];
  logic             nxt_c [STAGES];
  logic             nxt_v [STAGES];

  logic [WIDTH-1:0] cur_a, cur_b, cur_s;
  logic             cur_c, cur_v;
  logic [4:0]       grp;
  logic [WIDTH-1:0] raw, res;
  logic             ovfl_c;

  // Returns {carry_out, sum[3:0]}; carry_out is formed from group G/P.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g, p, c;
    logic       gg, pp;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (&p[2:0] & ci);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (&p[3:1] & g[0]);
    pp   = &p;
    return {gg | (pp & ci), p ^ c};
  endfunction

  always_comb begin
    cur_a = '0;
    cur_b = '0;
    cur_s = '0;
    cur_c = 1'b0;
    cur_v = 1'b0;
    grp   = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        cur_a = a;
        cur_b = sub ? ~b : b;
        cur_s = '0;
        cur_c = sub;
        cur_v = in_valid;
      end else begin
        cur_a = a_r[k];
        cur_b = b_r[k];
        cur_s = s_r[k];
        cur_c = c_r[k];
        cur_v = v_r[k];
      end
      for (int g = 0; g < GPS; g++) begin
        grp = cla4(cur_a[(k*GPS+g)*4 +: 4], cur_b[(k*GPS+g)*4 +: 4], cur_c);
        cur_s[(k*GPS+g)*4 +: 4] = grp[3:0];
        cur_c = grp[4];
      end
      nxt_a[k] = cur_a;
      nxt_b[k] = cur_b;
      nxt_s[k] = cur_s;
      nxt_c[k] = cur_c;
      nxt_v[k] = cur_v;
    end

    raw    = nxt_s[STAGES-1];
    ovfl_c = (nxt_a[STAGES-1][MSB] == nxt_b[STAGES-1][MSB]) &
             (raw[MSB] != nxt_a[STAGES-1][MSB]);
`ifdef ADDSUB_SAT_EN
    // Overflow direction always follows the sign of a.
    if (ovfl_c) res = nxt_a[STAGES-1][MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    else        res = raw;
`else
    res = raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      ovfl      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      for (int k = 1; k < STAGES; k++) begin
        v_r[k] <= 1'b0;
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
        c_r[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 1; k < STAGES; k++) begin
        v_r[k] <= nxt_v[k-1];
        a_r[k] <= nxt_a[k-1];
        b_r[k] <= nxt_b[k-1];
        s_r[k] <= nxt_s[k-1];
        c_r[k] <= nxt_c[k-1];
      end
      out_valid <= nxt_v[STAGES-1];
      // Bubbles leave the last result and its flags on the outputs.
      if (nxt_v[STAGES-1]) begin
        sum  <= res;
        ovfl <= ovfl_c;
        zero <= (res == '0);
        neg  <= res[MSB];
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe_sat.sv
// Bench for addsub_pipe_sat (WIDTH=16, STAGES=2); result model built from exact
// integer arithmetic, honouring ADDSUB_SAT_EN when defined.
module tb_addsub_pipe_sat;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        ovfl, zero, neg;

  addsub_pipe_sat #(.WIDTH(16), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovfl(ovfl), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  int          cmp_cnt = 0;
  int          fail_cnt = 0;
  int          cyc = 0;
  int          stalls = 0;
  logic [18:0] exp_q[$];
  int          acc_cyc_q[$];
  int          acc_stall_q[$];
  logic        held_valid = 1'b0;
  logic [18:0] held = '0;
  logic        rst_prev = 1'b0;
  logic        last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed as {ovfl, zero, neg, sum}.
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s);
    int          sx, sy, ex;
    logic        ov;
    logic [15:0] r;
    sx = $signed(x);
    sy = $signed(y);
    ex = s ? (sx - sy) : (sx + sy);
    ov = (ex > 32767) || (ex < -32768);
    r  = ex[15:0];
`ifdef ADDSUB_SAT_EN
    if (ov) r = (ex > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {ov, (r == 16'h0000), r[15], r};
  endfunction

  // Sample mid-cycle, score, then advance one clock.
  task automatic cycle();
    logic [18:0] obs;
    @(negedge clk);
    obs = {ovfl, zero, neg, sum};
    last_acc = 1'b0;
    if (rst_prev) chk("reset_outputs", {out_valid, obs}, 32'h0);
    if (rst_prev && !rst) chk("post_reset_in_ready", in_ready, 1);
    if (rst) begin
      exp_q.delete();
      acc_cyc_q.delete();
      acc_stall_q.delete();
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", obs, held);
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        stalls++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", out_valid, 0);
        else begin
          int ac, as;
          chk("beat", obs, exp_q.pop_front());
          ac = acc_cyc_q.pop_front();
          as = acc_stall_q.pop_front();
          if (as == stalls) chk("latency", cyc - ac, 2);
        end
      end
      held_valid = out_valid && !out_ready;
      held       = obs;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub));
        acc_cyc_q.push_back(cyc);
        acc_stall_q.push_back(stalls);
        last_acc = 1'b1;
      end
    end
    rst_prev = rst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic s);
    int n;
    in_valid = 1'b1;
    a = x;
    b = y;
    sub = s;
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 20) begin
      cycle();
      n++;
    end
    if (!last_acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    int k, i;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    a = 16'h1234;
    b = 16'h1111;
    sub = 1'b0;

    // Reset held with in_valid high; outputs must stay cleared.
    repeat (4) cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    cycle();

    // Overflow corners, zero result, and carry across the stage boundary.
    send(16'h7FFF, 16'h0001, 1'b0);
    repeat (3) cycle();
    send(16'h8000, 16'h0001, 1'b1);
    send(16'h0005, 16'h0005, 1'b1);
    send(16'h0FFF, 16'h0001, 1'b0);
    send(16'h00FF, 16'h0001, 1'b0);
    send(16'h0000, 16'h8000, 1'b1);
    send(16'h8000, 16'h8000, 1'b0);
    repeat (3) cycle();

    // Eight back-to-back beats with the consumer stalling cycles 3-5.
    k = 0;
    i = 0;
    while (k < 8 && i < 40) begin
      in_valid  = 1'b1;
      a         = 16'h1000 * 16'(k) + 16'h0FFF;
      b         = 16'h0001 + 16'(k);
      sub       = k[0];
      out_ready = !(i >= 3 && i <= 5);
      cycle();
      if (last_acc) k++;
      i++;
    end
    chk("b2b_accepted", k, 8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();

    // Reset with two beats in flight; nothing of them may emerge.
    in_valid = 1'b1;
    a = 16'h0100; b = 16'h0023; sub = 1'b0;
    cycle();
    a = 16'h7000; b = 16'h1000; sub = 1'b1;
    cycle();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (3) cycle();
    send(16'h1234, 16'h4321, 1'b0);
    repeat (3) cycle();

    // Random traffic with random consumer back-pressure.
    for (int n = 0; n < 300; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      a         = pick();
      b         = pick();
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      cycle();
      k++;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
